// File: rtl/higher_memory_arbiter.sv
// Purpose : round-robin arbiter from the two L1 caches (0 = icache, 1 = dcache) onto the single higher-memory port.
// Latency : a request sampled in IDLE is visible downstream the next cycle; the fulfilment returns to the owner combinationally.
// Backpr. : one request outstanding at a time; the losing port's valid stays pending until it is granted.
//
// Ports:
//   clk, reset (async, active-low)
//   reqN_address/operation/store_word/valid : upstream requests, N = 0,1
//   reqN_loaded_word/fulfilled              : responses routed back to the owner
//   mem_req_address/operation/store_word/valid : registered downstream request
//   mem_req_loaded_word/fulfilled           : downstream response
//   protocol_error                          : sticky, set by a fulfilment strobe while IDLE

package higher_memory_arbiter_pkg;
    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } memory_operation_e;
endpackage

module higher_memory_arbiter
    import higher_memory_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [XLEN-1:0]   req0_address,
    input  memory_operation_e req0_operation,
    input  logic [XLEN-1:0]   req0_store_word,
    input  logic              req0_valid,
    output logic [XLEN-1:0]   req0_loaded_word,
    output logic              req0_fulfilled,

    input  logic [XLEN-1:0]   req1_address,
    input  memory_operation_e req1_operation,
    input  logic [XLEN-1:0]   req1_store_word,
    input  logic              req1_valid,
    output logic [XLEN-1:0]   req1_loaded_word,
    output logic              req1_fulfilled,

    output logic [XLEN-1:0]   mem_req_address,
    output memory_operation_e mem_req_operation,
    output logic [XLEN-1:0]   mem_req_store_word,
    output logic              mem_req_valid,
    input  logic [XLEN-1:0]   mem_req_loaded_word,
    input  logic              mem_req_fulfilled,

    output logic              protocol_error
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [XLEN-1:0]   r_address;
    memory_operation_e r_operation;
    logic [XLEN-1:0]   r_store_word;
    logic              r_protocol_error;

    logic              w_any_vld;
    logic              w_winner;
    logic [XLEN-1:0]   w_sel_address;
    memory_operation_e w_sel_operation;
    logic [XLEN-1:0]   w_sel_store_word;

    assign w_any_vld = req0_valid | req1_valid;

    // On a tie the port that did not win last time goes; otherwise the lone
    // valid port wins (req1_valid alone selects 1, req0_valid alone selects 0).
    assign w_winner = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

    assign w_sel_address    = w_winner ? req1_address    : req0_address;
    assign w_sel_operation  = w_winner ? req1_operation  : req0_operation;
    assign w_sel_store_word = w_winner ? req1_store_word : req0_store_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_owner          <= 1'b0;
            r_last_grant     <= 1'b1;
            r_address        <= '0;
            r_operation      <= MEM_LOAD;
            r_store_word     <= '0;
            r_protocol_error <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            // A completion with nothing outstanding is flagged and otherwise dropped.
            if (mem_req_fulfilled) begin
                r_protocol_error <= 1'b1;
            end
            if (w_any_vld) begin
                r_state      <= ST_BUSY;
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_address    <= w_sel_address;
                r_operation  <= w_sel_operation;
                r_store_word <= w_sel_store_word;
            end
        end else begin
            // Upstream valids are not looked at here, so the loser simply
            // waits with its valid held and is resampled back in IDLE.
            if (mem_req_fulfilled) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign mem_req_valid      = (r_state == ST_BUSY);
    assign mem_req_address    = r_address;
    assign mem_req_operation  = r_operation;
    assign mem_req_store_word = r_store_word;
    assign protocol_error     = r_protocol_error;

    assign req0_fulfilled = mem_req_valid & mem_req_fulfilled & ~r_owner;
    assign req1_fulfilled = mem_req_valid & mem_req_fulfilled &  r_owner;

    // Load data is broadcast; each cache qualifies it with its own strobe.
    assign req0_loaded_word = mem_req_loaded_word;
    assign req1_loaded_word = mem_req_loaded_word;

endmodule
